// File: rtl/capture_multi_ts.sv
// capture_multi_ts: per-channel glitch filter, edge detector and timestamp capture
// with acknowledge/overflow tracking and a shared combinational readout mux.
module capture_multi_ts #(
    parameter int  CHANNELS  = 4,
    parameter int  FLT_WIDTH = 4,
    parameter int  TS_WIDTH  = 16,
    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [CHANNELS-1:0]             d,
    input  logic [CHANNELS*FLT_WIDTH-1:0]   flt_val,
    input  logic [2*CHANNELS-1:0]           edge_mode,
    input  logic [SEL_W-1:0]                rd_sel,
    input  logic                            rd_ack,
    output logic [CHANNELS-1:0]             filtered,
    output logic [CHANNELS-1:0]             edge_evt,
    output logic [TS_WIDTH-1:0]             rd_data,
    output logic [CHANNELS-1:0]             cap_valid,
    output logic [CHANNELS-1:0]             cap_ovf,
    output logic                            irq
);

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [FLT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [FLT_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CHANNELS-1:0]  filtered_q, filtered_d;
    logic [CHANNELS-1:0]  filt_prev_q, filt_prev_d;
    logic [TS_WIDTH-1:0]  cap_q [CHANNELS];
    logic [TS_WIDTH-1:0]  cap_d [CHANNELS];
    logic [CHANNELS-1:0]  cap_valid_q, cap_valid_d;
    logic [CHANNELS-1:0]  cap_ovf_q, cap_ovf_d;
    logic [CHANNELS-1:0]  rise, fall, evt, ack;

    // A pin only moves once it has disagreed with the filtered level for
    // flt_val+1 consecutive enabled samples; any agreeing sample restarts the count.
    always_comb begin
        ts_d        = ts_q;
        cnt_d       = cnt_q;
        filtered_d  = filtered_q;
        filt_prev_d = filt_prev_q;
        if (ena) begin
            ts_d        = ts_q + TS_WIDTH'(1);
            filt_prev_d = filtered_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (d[i] == filtered_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] < flt_val[i*FLT_WIDTH +: FLT_WIDTH]) begin
                    cnt_d[i] = cnt_q[i] + FLT_WIDTH'(1);
                end else begin
                    filtered_d[i] = d[i];
                    cnt_d[i]      = '0;
                end
            end
        end
    end

    always_comb begin
        rise = filtered_q & ~filt_prev_q;
        fall = ~filtered_q & filt_prev_q;
        evt  = '0;
        ack  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            evt[i] = ena & ((edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]));
            ack[i] = rd_ack & (rd_sel == SEL_W'(i));
        end
    end

    // An event always wins over an acknowledge; the ack then only clears the overflow.
    always_comb begin
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;
        cap_ovf_d   = cap_ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (evt[i]) begin
                cap_d[i]       = ts_q;
                cap_valid_d[i] = 1'b1;
                cap_ovf_d[i]   = ~ack[i] & (cap_valid_q[i] | cap_ovf_q[i]);
            end else if (ack[i]) begin
                cap_valid_d[i] = 1'b0;
                cap_ovf_d[i]   = 1'b0;
            end
        end
    end

    // Selections past the last channel match no entry and read back as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = cap_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            filtered_q  <= '0;
            filt_prev_q <= '0;
            cap_valid_q <= '0;
            cap_ovf_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                cap_q[i] <= '0;
            end
        end else begin
            ts_q        <= ts_d;
            cnt_q       <= cnt_d;
            filtered_q  <= filtered_d;
            filt_prev_q <= filt_prev_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            cap_ovf_q   <= cap_ovf_d;
        end
    end

    assign filtered  = filtered_q;
    assign edge_evt  = evt;
    assign cap_valid = cap_valid_q;
    assign cap_ovf   = cap_ovf_q;
    assign irq       = |cap_valid_q;

endmodule

// File: doc/capture_multi_ts.md
CAPTURE_MULTI_TS -- requirements
Module: capture_multi_ts

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent capture channels, 1..16.
REQ-002 SHALL have parameter FLT_WIDTH, default 4: width of each channel's filter threshold and counter.
REQ-003 SHALL have parameter TS_WIDTH, default 16: width of the timestamp counter and capture registers.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port ena  in  1  global enable; low freezes filters, edge detectors and timestamp.
REQ-007 SHALL have port d  in  CHANNELS  raw input pins, bit i = channel i.
REQ-008 SHALL have port flt_val  in  CHANNELS*FLT_WIDTH  per-channel filter threshold, channel i at [i*FLT_WIDTH +: FLT_WIDTH].
REQ-009 SHALL have port edge_mode  in  2*CHANNELS  per-channel mode: 00 off, 01 rise, 10 fall, 11 both.
REQ-010 SHALL have port rd_sel  in  max(1,clog2(CHANNELS))  channel selected for readout.
REQ-011 SHALL have port rd_ack  in  1  one-cycle pulse acknowledging channel rd_sel.
REQ-012 SHALL have port filtered  out  CHANNELS  filtered pin levels.
REQ-013 SHALL have port edge_evt  out  CHANNELS  one-cycle pulse on a selected edge of filtered.
REQ-014 SHALL have port rd_data  out  TS_WIDTH  capture register of channel rd_sel, combinational mux.
REQ-015 SHALL have port cap_valid  out  CHANNELS  capture register holds unacknowledged data.
REQ-016 SHALL have port cap_ovf  out  CHANNELS  capture overwritten while valid.
REQ-017 SHALL have port irq  out  1  OR of cap_valid, registered-free.

Function
REQ-018 Timestamp: TS_WIDTH free-running up-counter, +1 per cycle when ena=1, wraps max->0.
REQ-019 Filter per channel, when ena=1: if d==filtered, cnt<=0; else if cnt<flt_val, cnt<=cnt+1; else filtered<=d, cnt<=0.
REQ-020 Filter consequence: a change stable for flt_val+1 consecutive samples appears on filtered in the following cycle; shorter pulses are rejected; flt_val=0 gives one-cycle delay.
REQ-021 Filter threshold change SHALL take effect the next cycle, cnt unaffected; cnt>=new flt_val updates filtered on the next differing sample.
REQ-022 Edge detect: register filt_d<=filtered when ena=1; rise = filtered & ~filt_d, fall = ~filtered & filt_d; edge_evt = selected per edge_mode, gated by ena.
REQ-023 Capture: when edge_evt[i]=1, cap[i]<=current timestamp; cap_valid[i]<=1 next cycle; capture value = d arrival timestamp + flt_val + 1.
REQ-024 Overflow: edge_evt[i] while cap_valid[i]=1 and not acknowledged this cycle SHALL overwrite cap[i] and set cap_ovf[i].
REQ-025 rd_ack with no event on rd_sel channel SHALL clear cap_valid and cap_ovf of that channel next cycle; rd_data unchanged.
REQ-026 rd_ack coincident with edge_evt on the same channel SHALL capture new data, keep cap_valid=1, clear cap_ovf.
REQ-027 rd_ack SHALL be honoured regardless of ena; rd_sel >= CHANNELS SHALL make rd_ack a no-op and rd_data zero.
REQ-028 edge_mode=00 SHALL suppress edge_evt and capture; filtering and filt_d continue.
REQ-029 ena=0 SHALL hold timestamp, cnt, filtered, filt_d; edge_evt forced 0; no captures.

Reset
REQ-030 rst=1 at a clock edge SHALL clear timestamp, all cnt, filtered, filt_d, cap, cap_valid, cap_ovf to 0, overriding ena, rd_ack and any in-progress filter count.
REQ-031 After reset, a pin already high SHALL produce a rise after flt_val+1 samples, as a normal edge.

Verification
REQ-032 CHANNELS=4, flt_val[0]=3, mode 01: d[0] rises in cycle with ts=100, held -> filtered[0] high at ts=104, edge_evt[0] one cycle, cap[0]=104, cap_valid[0]=1 at ts=105, irq=1.
REQ-033 Glitch: flt_val=3, d[1] high exactly 3 cycles -> filtered[1], edge_evt[1], cap_valid[1] stay 0.
REQ-034 Mode 11 on ch2, flt_val=0: d pulse high ts=20..29 -> captures at ts=21 and 31; second without ack -> cap=31, cap_ovf[2]=1; rd_ack rd_sel=2 -> valid and ovf 0.
REQ-035 rd_ack for ch3 same cycle as its edge_evt at ts=50 -> cap[3]=50, cap_valid[3]=1, cap_ovf[3]=0.
REQ-036 ena low 5 cycles mid-filter (cnt=2) -> ts and cnt frozen, no edge; rst mid-filter -> all outputs 0 next cycle, ts restarts at 0.
